// File: rtl/w_grf_writeback_pkg.sv
// ---------------------------------------------------------------------------
// w_grf_writeback_pkg
// Shared definitions for the P7 write-back stage and general register file:
// the result-source select encoding and the register file geometry.
// Optional feature macro used by the register file: GRF_BYPASS_EN.
// ---------------------------------------------------------------------------
package w_grf_writeback_pkg;

  // Data path width and register address width of the MIPS GRF.
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // Return-address offset for jal/jalr/bgezal (link = PC + 8).
  localparam logic [DATA_W-1:0] LINK_OFFSET = 32'd8;

  // Write-back result source select; encodings 5-7 fall back to ALU.
  typedef enum logic [2:0] {
    WB_SEL_ALU  = 3'd0,
    WB_SEL_MEM  = 3'd1,
    WB_SEL_HILO = 3'd2,
    WB_SEL_CP0  = 3'd3,
    WB_SEL_PC8  = 3'd4
  } wb_sel_e;

  // Link address, wrapping modulo 2^32.
  function automatic logic [DATA_W-1:0] link_addr(input logic [DATA_W-1:0] pc);
    return pc + LINK_OFFSET;
  endfunction

endpackage

// File: rtl/w_grf_writeback_grf.sv
// ---------------------------------------------------------------------------
// w_grf_writeback_grf
// General register file: 31 x 32-bit registers ($1-$31), $0 hard-wired to 0.
// One synchronous write port, two combinational read ports, async active-low
// reset that clears every register.
// Macro GRF_BYPASS_EN: when defined, a read of the register being written in
// the same cycle returns the incoming write data (write-through).
//
// Ports:
//   clk      - clock, writes on rising edge
//   reset    - asynchronous, active-low
//   we       - write enable (already qualified, never set for $0 upstream)
//   waddr    - write register number
//   wdata    - write data
//   raddr_a  - read port A register number
//   raddr_b  - read port B register number
//   rdata_a  - read port A data
//   rdata_b  - read port B data
// ---------------------------------------------------------------------------
module w_grf_writeback_grf
  import w_grf_writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b
);

  // $0 has no storage; the array starts at register 1.
  logic [DATA_W-1:0] regs [1:31];

  // Storage update. The waddr check is repeated here so the array can never
  // be asked to store into the non-existent $0 slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port A. Address 0 short-circuits to 0 before any array access or
  // bypass, so $0 reads 0 in both configurations.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) begin
      rdata_a = regs[raddr_a];
`ifdef GRF_BYPASS_EN
      if (we && (raddr_a == waddr)) begin
        rdata_a = wdata;
      end
`endif
    end
  end

  // Read port B, identical structure to port A so both ports always agree
  // when they read the same address.
  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) begin
      rdata_b = regs[raddr_b];
`ifdef GRF_BYPASS_EN
      if (we && (raddr_b == waddr)) begin
        rdata_b = wdata;
      end
`endif
    end
  end

endmodule

// File: rtl/w_grf_writeback.sv
// ---------------------------------------------------------------------------
// w_grf_writeback
// Write-back stage of the P7 five-stage MIPS core: selects the result to
// commit, qualifies the register write, hosts the general register file
// serving the D-stage read ports, and counts retired instructions.
// Optional feature macro: GRF_BYPASS_EN (same-cycle write-through in the GRF).
//
// Ports:
//   clk                - clock
//   reset              - asynchronous, active-low
//   W_instr            - W-stage instruction, 0 = bubble/flushed slot
//   W_PC               - W-stage PC
//   W_ALU_result       - ALU result
//   W_HI_LO            - mfhi/mflo data
//   W_MEM_read_data    - load data (already extended)
//   W_CP0_read_data    - mfc0 data
//   W_result_sel       - result source select (wb_sel_e)
//   W_REG_write_number - destination register
//   W_REG_write_enable - commit enable
//   D_rs_number        - read port A address
//   D_rt_number        - read port B address
//   D_rs_data          - read port A data
//   D_rt_data          - read port B data
//   W_REG_write_data   - selected result, also the W forwarding source
//   W_commit           - write enable qualified by nonzero destination
//   retire_count       - retired non-bubble instruction count (wraps)
// ---------------------------------------------------------------------------
module w_grf_writeback
  import w_grf_writeback_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         W_instr,
  input  logic [31:0]         W_PC,
  input  logic [31:0]         W_ALU_result,
  input  logic [31:0]         W_HI_LO,
  input  logic [31:0]         W_MEM_read_data,
  input  logic [31:0]         W_CP0_read_data,
  input  logic [2:0]          W_result_sel,
  input  logic [4:0]          W_REG_write_number,
  input  logic                W_REG_write_enable,
  input  logic [4:0]          D_rs_number,
  input  logic [4:0]          D_rt_number,
  output logic [31:0]         D_rs_data,
  output logic [31:0]         D_rt_data,
  output logic [31:0]         W_REG_write_data,
  output logic                W_commit,
  output logic [RETIRE_W-1:0] retire_count
);

  // Result source mux. Unused encodings default to the ALU result.
  always_comb begin
    W_REG_write_data = W_ALU_result;
    case (wb_sel_e'(W_result_sel))
      WB_SEL_MEM:  W_REG_write_data = W_MEM_read_data;
      WB_SEL_HILO: W_REG_write_data = W_HI_LO;
      WB_SEL_CP0:  W_REG_write_data = W_CP0_read_data;
      WB_SEL_PC8:  W_REG_write_data = link_addr(W_PC);
      default:     W_REG_write_data = W_ALU_result;
    endcase
  end

  // Writes to $0 are architecturally discarded, so they never commit.
  assign W_commit = W_REG_write_enable && (W_REG_write_number != '0);

  // Every non-bubble instruction retires, including stores and branches
  // that do not write the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count <= '0;
    end else if (W_instr != '0) begin
      retire_count <= retire_count + 1'b1;
    end
  end

  w_grf_writeback_grf u_grf (
    .clk     (clk),
    .reset   (reset),
    .we      (W_commit),
    .waddr   (W_REG_write_number),
    .wdata   (W_REG_write_data),
    .raddr_a (D_rs_number),
    .raddr_b (D_rt_number),
    .rdata_a (D_rs_data),
    .rdata_b (D_rt_data)
  );

endmodule

// File: tb/tb_w_grf_writeback.sv
// ---------------------------------------------------------------------------
// tb_w_grf_writeback
// Self-checking bench for w_grf_writeback. A reference model (register array,
// retire counter and result-select rule) runs alongside two instances: one
// with the default 32-bit retire counter and one with a 4-bit counter to
// exercise wrap-around. Honours GRF_BYPASS_EN when computing read results.
// ---------------------------------------------------------------------------
module tb_w_grf_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_instr, W_PC, W_ALU_result, W_HI_LO, W_MEM_read_data, W_CP0_read_data;
  logic [2:0]  W_result_sel;
  logic [4:0]  W_REG_write_number;
  logic        W_REG_write_enable;
  logic [4:0]  D_rs_number, D_rt_number;

  logic [31:0] D_rs_data, D_rt_data, W_REG_write_data;
  logic        W_commit;
  logic [31:0] retire_count;

  logic [31:0] rs4, rt4, wd4;
  logic        commit4;
  logic [3:0]  retire4;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] model_regs [32];
  longint      model_retire;

`ifdef GRF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  w_grf_writeback dut (
    .clk(clk), .reset(reset), .W_instr(W_instr), .W_PC(W_PC),
    .W_ALU_result(W_ALU_result), .W_HI_LO(W_HI_LO),
    .W_MEM_read_data(W_MEM_read_data), .W_CP0_read_data(W_CP0_read_data),
    .W_result_sel(W_result_sel), .W_REG_write_number(W_REG_write_number),
    .W_REG_write_enable(W_REG_write_enable), .D_rs_number(D_rs_number),
    .D_rt_number(D_rt_number), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .W_REG_write_data(W_REG_write_data), .W_commit(W_commit),
    .retire_count(retire_count)
  );

  w_grf_writeback #(.RETIRE_W(4)) dut4 (
    .clk(clk), .reset(reset), .W_instr(W_instr), .W_PC(W_PC),
    .W_ALU_result(W_ALU_result), .W_HI_LO(W_HI_LO),
    .W_MEM_read_data(W_MEM_read_data), .W_CP0_read_data(W_CP0_read_data),
    .W_result_sel(W_result_sel), .W_REG_write_number(W_REG_write_number),
    .W_REG_write_enable(W_REG_write_enable), .D_rs_number(D_rs_number),
    .D_rt_number(D_rt_number), .D_rs_data(rs4), .D_rt_data(rt4),
    .W_REG_write_data(wd4), .W_commit(commit4), .retire_count(retire4)
  );

  // Expected result value from the current W inputs.
  function automatic logic [31:0] model_result();
    case (W_result_sel)
      3'd1:    return W_MEM_read_data;
      3'd2:    return W_HI_LO;
      3'd3:    return W_CP0_read_data;
      3'd4:    return W_PC + 32'd8;
      default: return W_ALU_result;
    endcase
  endfunction

  function automatic logic model_commit();
    return W_REG_write_enable && (W_REG_write_number != 5'd0);
  endfunction

  // Expected read data for an address in the current cycle.
  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (BYPASS && model_commit() && addr == W_REG_write_number) return model_result();
    return model_regs[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_retire = 0;
  endtask

  task automatic set_w(input logic [31:0] instr, input logic [2:0] sel,
                       input logic [31:0] value, input logic [31:0] pc,
                       input logic [4:0] wnum, input logic we);
    W_instr = instr;
    W_result_sel = sel;
    W_ALU_result = value;
    W_MEM_read_data = value;
    W_HI_LO = value;
    W_CP0_read_data = value;
    W_PC = pc;
    W_REG_write_number = wnum;
    W_REG_write_enable = we;
  endtask

  task automatic set_bubble();
    set_w(32'd0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  // Advance one rising edge, update the model from the inputs held across
  // it, then return at the following falling edge.
  task automatic clock_edge();
    logic [31:0] res;
    logic        cm;
    logic        in_reset;
    res = model_result();
    cm = model_commit();
    @(posedge clk);
    in_reset = !reset;
    if (!in_reset) begin
      if (cm) model_regs[W_REG_write_number] = res;
      if (W_instr != 32'd0) model_retire = model_retire + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    set_bubble();
    D_rs_number = 5'd0;
    D_rt_number = 5'd0;
    #3;
    for (int a = 0; a < 32; a += 9) begin
      D_rs_number = 5'(a);
      D_rt_number = 5'(31 - a);
      #1;
      checks++;
      if (D_rs_data !== 32'd0 || D_rt_data !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_read a=%0d: got %h/%h expected 0", a, D_rs_data, D_rt_data);
      end
    end
    checks++;
    if (retire_count !== 32'd0 || retire4 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_retire: got %0d/%0d expected 0", retire_count, retire4);
    end
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_zero_reg();
    set_w(32'h8C00_0000, 3'd1, 32'hDEAD_BEEF, 32'h3000, 5'd0, 1'b1);
    D_rs_number = 5'd0;
    #1;
    checks++;
    if (W_commit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_commit: got %b expected 0", W_commit);
    end
    checks++;
    if (W_REG_write_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL zero_sel_mem: got %h expected deadbeef", W_REG_write_data);
    end
    clock_edge();
    set_bubble();
    #1;
    checks++;
    if (D_rs_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL zero_read: got %h expected 0", D_rs_data);
    end
  endtask

  task automatic test_pc8();
    set_w(32'h0C00_0000, 3'd4, 32'h1111_1111, 32'h0000_3000, 5'd31, 1'b1);
    #1;
    checks++;
    if (W_REG_write_data !== 32'h0000_3008) begin
      errors++;
      $display("[TB] FAIL pc8_data: got %h expected 00003008", W_REG_write_data);
    end
    clock_edge();
    set_bubble();
    D_rs_number = 5'd31;
    #1;
    checks++;
    if (D_rs_data !== 32'h0000_3008) begin
      errors++;
      $display("[TB] FAIL pc8_read: got %h expected 00003008", D_rs_data);
    end
    set_w(32'h0C00_0000, 3'd4, 32'h0, 32'hFFFF_FFFC, 5'd30, 1'b1);
    #1;
    checks++;
    if (W_REG_write_data !== 32'h0000_0004) begin
      errors++;
      $display("[TB] FAIL pc8_wrap: got %h expected 00000004", W_REG_write_data);
    end
    clock_edge();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_now;
    set_w(32'h2408_0001, 3'd0, 32'h0000_0001, 32'h3010, 5'd8, 1'b1);
    clock_edge();
    set_w(32'h2408_A5A5, 3'd0, 32'hA5A5_A5A5, 32'h3014, 5'd8, 1'b1);
    D_rs_number = 5'd8;
    D_rt_number = 5'd8;
    exp_now = BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0001;
    #1;
    checks++;
    if (D_rs_data !== exp_now || D_rt_data !== exp_now) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got %h/%h expected %h", D_rs_data, D_rt_data, exp_now);
    end
    clock_edge();
    set_bubble();
    #1;
    checks++;
    if (D_rs_data !== 32'hA5A5_A5A5 || D_rt_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("[TB] FAIL bypass_after_edge: got %h/%h expected a5a5a5a5", D_rs_data, D_rt_data);
    end
  endtask

  task automatic test_reset_midrun();
    set_w(32'h2405_0000, 3'd0, 32'h1234_5678, 32'h3020, 5'd5, 1'b1);
    clock_edge();
    set_bubble();
    D_rs_number = 5'd5;
    #1;
    checks++;
    if (D_rs_data !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL midrun_pre: got %h expected 12345678", D_rs_data);
    end
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (D_rs_data !== 32'd0 || retire_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got %h cnt %0d expected 0 cnt 0", D_rs_data, retire_count);
    end
    #1 reset = 1'b1;
    // Reset over an edge with a commit pending: the write must be lost.
    set_w(32'h2406_0000, 3'd0, 32'hCAFE_F00D, 32'h3024, 5'd6, 1'b1);
    #1 reset = 1'b0;
    clock_edge();
    reset = 1'b1;
    set_bubble();
    D_rt_number = 5'd6;
    #1;
    checks++;
    if (D_rt_data !== 32'd0 || retire_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_commit_lost: got %h cnt %0d expected 0 cnt 0", D_rt_data, retire_count);
    end
  endtask

  task automatic test_retire();
    reset = 1'b0;
    model_clear();
    #1 reset = 1'b1;
    set_w(32'h0000_0021, 3'd0, 32'h5, 32'h3000, 5'd3, 1'b1); clock_edge();
    set_bubble(); clock_edge();
    set_w(32'hAC01_0000, 3'd0, 32'h7, 32'h3004, 5'd0, 1'b0); clock_edge();
    set_bubble(); clock_edge();
    set_w(32'h1000_FFFF, 3'd0, 32'h9, 32'h3008, 5'd4, 1'b0); clock_edge();
    set_bubble();
    #1;
    checks++;
    if (retire_count !== 32'd3) begin
      errors++;
      $display("[TB] FAIL retire_three: got %0d expected 3", retire_count);
    end
    // Bring the 4-bit counter to 15, then one more instruction wraps it.
    for (int i = 0; i < 12; i++) begin
      set_w(32'h0000_0000 | 32'(i + 1), 3'd0, 32'h0, 32'h3100, 5'd0, 1'b0);
      clock_edge();
    end
    set_bubble();
    #1;
    checks++;
    if (retire4 !== 4'd15) begin
      errors++;
      $display("[TB] FAIL retire4_preload: got %0d expected 15", retire4);
    end
    set_w(32'h0000_0001, 3'd0, 32'h0, 32'h3200, 5'd0, 1'b0);
    clock_edge();
    set_bubble();
    #1;
    checks++;
    if (retire4 !== 4'd0 || retire_count !== 32'd16) begin
      errors++;
      $display("[TB] FAIL retire4_wrap: got %0d/%0d expected 0/16", retire4, retire_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_wd, exp_rs, exp_rt;
    logic        exp_cm;
    for (int n = 0; n < 300; n++) begin
      W_instr = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      W_PC = $urandom;
      W_ALU_result = $urandom;
      W_HI_LO = $urandom;
      W_MEM_read_data = $urandom;
      W_CP0_read_data = $urandom;
      W_result_sel = 3'($urandom_range(0, 7));
      W_REG_write_number = 5'($urandom);
      W_REG_write_enable = (W_instr != 32'd0) && ($urandom_range(0, 3) != 0);
      D_rs_number = ($urandom_range(0, 2) == 0) ? W_REG_write_number : 5'($urandom);
      D_rt_number = ($urandom_range(0, 2) == 0) ? W_REG_write_number : 5'($urandom);
      exp_wd = model_result();
      exp_cm = model_commit();
      exp_rs = model_read(D_rs_number);
      exp_rt = model_read(D_rt_number);
      #1;
      checks++;
      if (W_REG_write_data !== exp_wd || wd4 !== exp_wd) begin
        errors++;
        $display("[TB] FAIL rand_wdata n=%0d: got %h expected %h", n, W_REG_write_data, exp_wd);
      end
      checks++;
      if (W_commit !== exp_cm || commit4 !== exp_cm) begin
        errors++;
        $display("[TB] FAIL rand_commit n=%0d: got %b expected %b", n, W_commit, exp_cm);
      end
      checks++;
      if (D_rs_data !== exp_rs || D_rt_data !== exp_rt || rs4 !== exp_rs || rt4 !== exp_rt) begin
        errors++;
        $display("[TB] FAIL rand_read n=%0d rs=%0d rt=%0d: got %h/%h expected %h/%h",
                 n, D_rs_number, D_rt_number, D_rs_data, D_rt_data, exp_rs, exp_rt);
      end
      checks++;
      if (retire_count !== 32'(model_retire) || retire4 !== 4'(model_retire)) begin
        errors++;
        $display("[TB] FAIL rand_retire n=%0d: got %0d/%0d expected %0d",
                 n, retire_count, retire4, model_retire);
      end
      clock_edge();
    end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_pc8();
    test_bypass();
    test_reset_midrun();
    test_retire();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/w_grf_writeback.md
# w_grf_writeback

Write-back stage and general register file for the P7 five-stage MIPS core. Consumes the W-stage outputs of the M/W pipeline register and selects the 32-bit result to commit. It performs the register write and serves the two D-stage read ports. It also keeps a retired-instruction counter for the CP0 and debug interface.

## Interface

Parameters:
- `RETIRE_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `W_instr`, input, 32: W-stage instruction. 0 marks a bubble or a flushed slot.
- `W_PC`, input, 32: W-stage PC.
- `W_ALU_result`, input, 32: ALU result.
- `W_HI_LO`, input, 32: mfhi/mflo data.
- `W_MEM_read_data`, input, 32: load data, already extended.
- `W_CP0_read_data`, input, 32: mfc0 data.
- `W_result_sel`, input, 3: result source select (encoding in Structure).
- `W_REG_write_number`, input, 5: destination register.
- `W_REG_write_enable`, input, 1: commit enable.
- `D_rs_number`, input, 5: read port A address.
- `D_rt_number`, input, 5: read port B address.
- `D_rs_data`, output, 32: read port A data.
- `D_rt_data`, output, 32: read port B data.
- `W_REG_write_data`, output, 32: selected result; also the forwarding source for E and M.
- `W_commit`, output, 1: `W_REG_write_enable && W_REG_write_number != 0`.
- `retire_count`, output, RETIRE_W: number of retired non-bubble instructions.

## Operation

- **Result select** (combinational):
  - ALU → `W_ALU_result`; MEM → `W_MEM_read_data`; HILO → `W_HI_LO`; CP0 → `W_CP0_read_data`; PC8 → `W_PC + 32'd8`, modulo 2^32.
  - Any unlisted encoding (5–7) selects ALU.
- **Register file:**
  - 31 × 32-bit registers, `$1`–`$31`.
  - `$0` is not stored and always reads 0.
  - When `W_commit` is 1, `grf[W_REG_write_number] <= W_REG_write_data`.
- **Reads:**
  - Combinational, indexed by `D_rs_number` and `D_rt_number`.
  - Address 0 returns 0, regardless of any write in progress.
- **Retire counter:**
  - Increments by 1 on each clock edge where `W_instr != 0`, independent of the write enable (sw, beq and similar also retire).
  - Wraps from all-ones to 0.
- **Stall:** the block has no stall or flush input. The upstream register presents bubbles (`W_instr = 0`, `W_REG_write_enable = 0`), which neither write nor count.

## Timing

- **Reset** (`reset == 0`, asynchronous): every GRF entry and `retire_count` are forced to 0 immediately and stay 0 while reset is held.
- **Reset release:** the first update occurs on the first rising edge with `reset == 1`.
- **Write latency:** a commit on edge N is visible to non-bypassed reads after edge N.
- **Same-cycle read of the write target:** governed by `GRF_BYPASS_EN`.
- **Simultaneous reads:** both ports may read the same address, including the one being written; both return identical data.
- **Reset asserted mid-cycle while `W_commit` is 1:** the write is lost and the register reads 0.
- **Output timing:** `W_REG_write_data` and `W_commit` are purely combinational from W inputs, with no added latency.

## Configuration

- Macro: `GRF_BYPASS_EN`.
- **Defined:** internal write-through.
  - If `W_commit` is 1 and the read address equals a nonzero `W_REG_write_number`, the port returns `W_REG_write_data` in the same cycle.
  - The hazard unit need not forward W to D.
- **Undefined:** reads return the stored (old) value until the edge.
  - The D-stage forward mux must select W data itself, or the hazard unit must stall.
- `$0` reads 0 in both modes.

## Structure

- **Shared `macros.v`** gains:
  - `WB_SEL_ALU` = 3'd0
  - `WB_SEL_MEM` = 3'd1
  - `WB_SEL_HILO` = 3'd2
  - `WB_SEL_CP0` = 3'd3
  - `WB_SEL_PC8` = 3'd4
  - `GRF_BYPASS_EN` is set there when wanted.
- **Sub-module `grf`:** the storage array, read ports, bypass and async reset.
- **`w_grf_writeback`:** holds the result mux, the commit qualification and the retire counter.

## Test plan

- **Reset mid-run:** write `$5 = 0x12345678`, then pulse `reset` low between edges → `D_rs_data` for `$5` reads 0 immediately; `retire_count == 0`.
- **Select / `$0`:** sel=MEM, data `0xDEADBEEF`, write to `$0` → `W_commit == 0`; `$0` reads 0 next cycle.
- **PC8:** sel=PC8, `W_PC = 0x00003000`, write `$31` → `$31` reads `0x00003008` after the edge.
- **PC8 wrap:** `W_PC = 0xFFFFFFFC` → `W_REG_write_data == 0x00000004`.
- **Bypass:** write `$8 = 0xA5A5A5A5` while `D_rs_number = D_rt_number = 8`, and `$8` holds `0x1` →
  - both ports return `0xA5A5A5A5` in the same cycle with `GRF_BYPASS_EN`;
  - both return `0x1` without it, then `0xA5A5A5A5` after the edge.
- **Retire counting:**
  - 3 valid instructions (one is sw, enable 0) interleaved with 2 bubbles → `retire_count == 3`.
  - With `RETIRE_W = 4`, preloaded to 15, one valid instruction → 0.
